// File: rtl/apb_regfile_slave.sv
// APB3/APB4 completer fronting a word-addressed register file with byte strobes and error response.
// Latency: pready rises in access cycle WAIT_STATES+1 after setup; prdata/pslverr are registered with it.
// Backpressure: pready is held low for WAIT_STATES access cycles; dropping psel mid-access aborts the transfer.
module apb_regfile_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic                    pslverr,
    output logic [DATA_WIDTH-1:0]   prdata
);

    localparam int NB         = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(NB);
    localparam int IDX_W      = ADDR_WIDTH - BYTE_SHIFT;
    localparam int RIDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IDX_W:0]      DEPTH_L    = (IDX_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << BYTE_SHIFT) - 1);
    localparam logic [3:0]          WS_L       = 4'(WAIT_STATES);
    localparam logic                ZERO_WAIT  = (WAIT_STATES == 0);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    // Setup-phase values captured once; later changes on the bus are not rechecked.
    typedef struct packed {
        logic                  write;
        logic                  err;
        logic [IDX_W-1:0]      idx;
        logic [NB-1:0]         strb;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [0:0]            state;
    logic [3:0]            wait_cnt;
    req_t                  req;
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic [IDX_W-1:0]      setup_idx;
    logic                  setup_err;
    logic [DATA_WIDTH-1:0] setup_rdata;
    logic [DATA_WIDTH-1:0] req_rdata;
    logic                  setup_go;
    logic                  access_go;
    logic                  complete;

    assign setup_idx = paddr[ADDR_WIDTH-1:BYTE_SHIFT];
    assign setup_err = ({1'b0, setup_idx} >= DEPTH_L) || ((paddr & ALIGN_MASK) != '0);

    // Errors and writes return zero so prdata is only ever non-zero on a good read.
    assign setup_rdata = (setup_err || pwrite) ? '0 : regs[setup_idx[RIDX_W-1:0]];
    assign req_rdata   = (req.err || req.write) ? '0 : regs[req.idx[RIDX_W-1:0]];

    assign setup_go  = (state == S_IDLE) && psel && !penable;
    assign complete  = (state == S_ACCESS) && psel && penable && pready;
    assign access_go = (state == S_ACCESS) && psel && penable && !pready && (wait_cnt != 4'd0);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            req      <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (setup_go) begin
                        state    <= S_ACCESS;
                        wait_cnt <= WS_L;
                        req      <= '{write: pwrite, err: setup_err, idx: setup_idx,
                                      strb: pstrb, wdata: pwdata};
                        pready   <= ZERO_WAIT;
                        pslverr  <= ZERO_WAIT && setup_err;
                        prdata   <= ZERO_WAIT ? setup_rdata : '0;
                    end
                end
                default: begin
                    if (!psel || complete) begin
                        state    <= S_IDLE;
                        wait_cnt <= 4'd0;
                        pready   <= 1'b0;
                        pslverr  <= 1'b0;
                        prdata   <= '0;
                    end else if (access_go) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= req.err;
                            prdata  <= req_rdata;
                        end
                    end
                end
            endcase
        end
    end

    // Commit happens only on the completion edge, so aborts and resets never write.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (complete && req.write && !req.err) begin
            for (int b = 0; b < NB; b++) begin
                if (req.strb[b]) begin
                    regs[req.idx[RIDX_W-1:0]][8*b +: 8] <= req.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (0, 3 and 2 wait states) checked every cycle
// against a transfer-level register model, plus literal checks of hand-computed results.
module tb_apb_regfile_slave;

    logic        pclk = 1'b0;
    logic        preset  [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [11:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [31:0] prdata  [3];

    logic        exp_rdy [3];
    logic        exp_err [3];
    logic [31:0] exp_dat [3];
    logic [31:0] mdl [3][64];
    logic        chk_on = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .prdata(prdata[0]));

    apb_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .prdata(prdata[1]));

    apb_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .preset(preset[2]), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]),
        .pready(pready[2]), .pslverr(pslverr[2]), .prdata(prdata[2]));

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    // Every cycle, every instance: outputs must equal what the transfer model expects.
    always @(negedge pclk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (pready[i] !== exp_rdy[i] || pslverr[i] !== exp_err[i] || prdata[i] !== exp_dat[i]) begin
                    n_errors++;
                    $display("FAIL cycle inst%0d t=%0t: got rdy=%b err=%b dat=%h, need rdy=%b err=%b dat=%h",
                             i, $time, pready[i], pslverr[i], prdata[i], exp_rdy[i], exp_err[i], exp_dat[i]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, need %h", nm, act, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic clr_exp(input int i);
        exp_rdy[i] = 1'b0;
        exp_err[i] = 1'b0;
        exp_dat[i] = '0;
    endtask

    // One full transfer starting #1 after an edge; returns #1 after the completion edge with the
    // bus released, so consecutive calls form back-to-back transfers with no idle cycle.
    task automatic xfer(input int i, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int abort_at,
                        output logic [31:0] rd, output logic err_o, output int rdy_n);
        int  ws;
        int  idx;
        bit  err;
        ws  = ws_of(i);
        idx = int'(addr >> 2);
        err = (idx >= 64) || (addr[1:0] != 2'b00);
        rd = '0; err_o = 1'b0; rdy_n = 0;
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr;
        paddr[i] = addr; pwdata[i] = data; pstrb[i] = strb;
        clr_exp(i);
        @(posedge pclk);
        #1;
        penable[i] = 1'b1;
        for (int n = 1; n <= ws + 1; n++) begin
            if (n == abort_at) begin
                psel[i] = 1'b0;
                penable[i] = 1'b0;
                return;
            end
            if (n == ws + 1) begin
                exp_rdy[i] = 1'b1;
                exp_err[i] = err;
                exp_dat[i] = (err || wr) ? 32'h0 : mdl[i][idx];
                rd    = prdata[i];
                err_o = pslverr[i];
            end
            if (pready[i] === 1'b1 && rdy_n == 0) rdy_n = n;
            @(posedge pclk);
            #1;
        end
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl[i][idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        psel[i] = 1'b0;
        penable[i] = 1'b0;
        clr_exp(i);
    endtask

    logic [31:0] rd;
    logic        e;
    int          rn;

    initial begin
        for (int i = 0; i < 3; i++) begin
            preset[i] = 1'b1; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
            clr_exp(i);
            for (int r = 0; r < 64; r++) mdl[i][r] = '0;
        end
        chk_on = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) preset[i] = 1'b0;

        // Zero wait states: reset value, then write/read.
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 0, rd, e, rn);
        chk("reset_reg_0x010", rd, 32'h0);
        xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, rd, e, rn);
        chk("ws0_write_ready_cycle", 32'(rn), 32'd1);
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 0, rd, e, rn);
        chk("ws0_read_data", rd, 32'hDEADBEEF);
        chk("ws0_read_err", 32'(e), 32'd0);
        chk("ws0_read_ready_cycle", 32'(rn), 32'd1);

        // Byte strobes.
        xfer(0, 1'b1, 12'h004, 32'h11223344, 4'hF, 0, rd, e, rn);
        xfer(0, 1'b1, 12'h004, 32'hAABBCCDD, 4'h5, 0, rd, e, rn);
        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, 0, rd, e, rn);
        chk("strobe_merge", rd, 32'h11BB33DD);
        idle(1);

        // psel & penable seen while idle must be ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 12'h010; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
        idle(2);
        psel[0] = 1'b0; penable[0] = 1'b0;
        idle(1);
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 0, rd, e, rn);
        chk("idle_enable_ignored", rd, 32'hDEADBEEF);

        // Errors: out-of-range and misaligned, no register disturbed.
        xfer(0, 1'b1, 12'h000, 32'h12345678, 4'hF, 0, rd, e, rn);
        xfer(0, 1'b1, 12'h100, 32'hFFFFFFFF, 4'hF, 0, rd, e, rn);
        chk("oor_write_err", 32'(e), 32'd1);
        xfer(0, 1'b1, 12'h006, 32'hFFFFFFFF, 4'hF, 0, rd, e, rn);
        chk("misaligned_write_err", 32'(e), 32'd1);
        xfer(0, 1'b0, 12'h002, 32'h0, 4'h0, 0, rd, e, rn);
        chk("misaligned_read_err", 32'(e), 32'd1);
        chk("misaligned_read_data", rd, 32'h0);
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, 0, rd, e, rn);
        chk("reg0_after_errors", rd, 32'h12345678);
        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, 0, rd, e, rn);
        chk("reg1_after_errors", rd, 32'h11BB33DD);

        // Back-to-back on zero wait states.
        xfer(0, 1'b1, 12'h020, 32'h01020304, 4'hF, 0, rd, e, rn);
        xfer(0, 1'b1, 12'h024, 32'h0A0B0C0D, 4'hF, 0, rd, e, rn);
        xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 0, rd, e, rn);
        chk("b2b_ws0_first", rd, 32'h01020304);
        xfer(0, 1'b0, 12'h024, 32'h0, 4'h0, 0, rd, e, rn);
        chk("b2b_ws0_second", rd, 32'h0A0B0C0D);
        idle(1);

        // Three wait states, abort, back-to-back.
        xfer(1, 1'b1, 12'h00C, 32'h0BADCAFE, 4'hF, 0, rd, e, rn);
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 0, rd, e, rn);
        chk("ws3_read_ready_cycle", 32'(rn), 32'd4);
        chk("ws3_read_data", rd, 32'h0BADCAFE);
        xfer(1, 1'b1, 12'h00C, 32'hFFFFFFFF, 4'hF, 2, rd, e, rn);
        idle(1);
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 0, rd, e, rn);
        chk("abort_no_write", rd, 32'h0BADCAFE);
        chk("abort_then_ready_cycle", 32'(rn), 32'd4);
        xfer(1, 1'b1, 12'h030, 32'hCAFE0001, 4'hF, 0, rd, e, rn);
        xfer(1, 1'b1, 12'h034, 32'hCAFE0002, 4'hF, 0, rd, e, rn);
        xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 0, rd, e, rn);
        chk("b2b_ws3_first", rd, 32'hCAFE0001);
        xfer(1, 1'b0, 12'h034, 32'h0, 4'h0, 0, rd, e, rn);
        chk("b2b_ws3_second", rd, 32'hCAFE0002);
        idle(1);

        // Reset during a pending write with two wait states.
        xfer(2, 1'b1, 12'h008, 32'hCAFEF00D, 4'hF, 0, rd, e, rn);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 12'h008; pwdata[2] = 32'h5555AAAA; pstrb[2] = 4'hF;
        idle(1);
        penable[2] = 1'b1;
        idle(2);
        #2;
        chk("pre_reset_ready", 32'(pready[2]), 32'd1);
        preset[2] = 1'b1;
        clr_exp(2);
        #1;
        chk("async_reset_ready", 32'(pready[2]), 32'd0);
        chk("async_reset_err", 32'(pslverr[2]), 32'd0);
        chk("async_reset_data", prdata[2], 32'h0);
        @(posedge pclk);
        #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        idle(1);
        preset[2] = 1'b0;
        for (int r = 0; r < 64; r++) mdl[2][r] = '0;
        idle(1);
        xfer(2, 1'b0, 12'h008, 32'h0, 4'h0, 0, rd, e, rn);
        chk("reg_after_reset", rd, 32'h0);
        chk("ws2_ready_cycle", 32'(rn), 32'd3);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
